// File: rtl/demultiplexer_unit_pkg.sv
// ============================================================================
//  Module   : demultiplexer_unit_pkg
//  Purpose  : Default geometry shared by the demultiplexer slice.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package demultiplexer_unit_pkg;
    localparam int DEF_SEL   = 2;
    localparam int DEF_WORD  = 8;
    localparam int DEF_CNT_W = 16;
endpackage

`default_nettype wire

// File: rtl/demultiplexer_unit_channel.sv
// ============================================================================
//  Module   : demux_channel
//  Purpose  : One-entry output buffer for a single demultiplexer channel.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_channel #(
    parameter int WORD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            pop,
    input  logic [WORD-1:0] DATAin,
    output logic [WORD-1:0] data_buf,
    output logic            v
);

    // A pop alone only clears valid; the data stays visible on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_buf <= '0;
            v        <= 1'b0;
        end else if (load) begin
            data_buf <= DATAin;
            v        <= 1'b1;
        end else if (pop) begin
            v        <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/demultiplexer_unit.sv
// ============================================================================
//  Module   : demultiplexer_unit
//  Purpose  : Registered 1-to-2**SEL demultiplexer with valid/ready per channel.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demultiplexer_unit
    import demultiplexer_unit_pkg::*;
#(
    parameter int SEL   = DEF_SEL,
    parameter int WORD  = DEF_WORD,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WORD-1:0]           DATAin,
    input  logic [SEL-1:0]            Select,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [(2**SEL)*WORD-1:0]  DATAout,
    output logic [(2**SEL)-1:0]       out_valid,
    input  logic [(2**SEL)-1:0]       out_ready,
    output logic [CNT_W-1:0]          routed_count
);

    localparam int NUM_CH = 2**SEL;

    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] v;
    logic              accept;

    // A full channel being drained this cycle can take the next word.
    assign in_ready = ~v[Select] | out_ready[Select];
    assign accept   = in_valid & in_ready;
    assign pop      = v & out_ready;

    always_comb begin
        load         = '0;
        load[Select] = accept;
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            demux_channel #(
                .WORD (WORD)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (load[i]),
                .pop      (pop[i]),
                .DATAin   (DATAin),
                .data_buf (DATAout[WORD*i +: WORD]),
                .v        (v[i])
            );
        end
    endgenerate

    assign out_valid = v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            routed_count <= '0;
        end else if (accept) begin
            routed_count <= routed_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_demultiplexer_unit.sv
// ============================================================================
//  Module   : tb_demultiplexer_unit
//  Purpose  : Self-checking bench for demultiplexer_unit against a queue-free
//             per-channel model, plus directed literal scenarios.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demultiplexer_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  DATAin = '0;
    logic [1:0]  Select = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  out_ready = '0;

    logic        in_ready;
    logic [31:0] DATAout;
    logic [3:0]  out_valid;
    logic [15:0] routed_count;

    logic        in_ready4;
    logic [31:0] DATAout4;
    logic [3:0]  out_valid4;
    logic [3:0]  routed_count4;

    int checks = 0;
    int failures = 0;

    demultiplexer_unit #(.SEL(2), .WORD(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .DATAin(DATAin), .Select(Select),
        .in_valid(in_valid), .in_ready(in_ready), .DATAout(DATAout),
        .out_valid(out_valid), .out_ready(out_ready), .routed_count(routed_count)
    );

    demultiplexer_unit #(.SEL(2), .WORD(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .DATAin(DATAin), .Select(Select),
        .in_valid(in_valid), .in_ready(in_ready4), .DATAout(DATAout4),
        .out_valid(out_valid4), .out_ready(out_ready), .routed_count(routed_count4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: one buffer and one full flag per channel, plus a count.
    logic [7:0]  mbuf [4] = '{default: 8'h00};
    logic [3:0]  mv = '0;
    logic [15:0] mcnt = '0;
    logic        stall_prev = 1'b0;
    logic [7:0]  pdata = '0;
    logic [1:0]  psel = '0;

    function automatic logic [31:0] model_dout();
        return {mbuf[3], mbuf[2], mbuf[1], mbuf[0]};
    endfunction

    function automatic logic model_ready();
        return !mv[Select] || out_ready[Select];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic acc;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mbuf[i] = 8'h00;
            mv = '0;
            mcnt = '0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("producer_hold", {in_valid, Select, DATAin}, {1'b1, psel, pdata});
            acc = in_valid && model_ready();
            stall_prev = in_valid && !model_ready();
            psel = Select;
            pdata = DATAin;
            for (int i = 0; i < 4; i++)
                if (mv[i] && out_ready[i]) mv[i] = 1'b0;
            if (acc) begin
                mbuf[Select] = DATAin;
                mv[Select] = 1'b1;
                mcnt = mcnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, model_ready());
        chk("out_valid", out_valid, mv);
        chk("DATAout", DATAout, model_dout());
        chk("routed_count", routed_count, mcnt);
        chk("routed_count4", routed_count4, mcnt[3:0]);
        chk("out_valid4", out_valid4, mv);
    end

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Reset applied without any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_DATAout", DATAout, 32'h0);
        chk("rst_count", routed_count, 16'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk) rst_n = 1'b1;

        in_valid = 1'b1; Select = 2'd2; DATAin = 8'hA5; out_ready = 4'b0000;
        tick();
        chk("s2_out_valid", out_valid, 4'b0100);
        chk("s2_DATAout", DATAout, 32'h00A5_0000);
        chk("s2_count", routed_count, 16'd1);
        in_valid = 1'b0;

        Select = 2'd2; DATAin = 8'h3C; in_valid = 1'b1;
        #1 chk("s3_stall_ready", in_ready, 1'b0);
        repeat (3) begin
            tick();
            chk("s3_hold_valid", out_valid, 4'b0100);
            chk("s3_hold_data", DATAout, 32'h00A5_0000);
            chk("s3_hold_count", routed_count, 16'd1);
        end
        out_ready = 4'b0100;
        #1 chk("s3_release_ready", in_ready, 1'b1);
        tick();
        chk("s3_slice2", DATAout[23:16], 8'h3C);
        chk("s3_valid2", out_valid[2], 1'b1);
        chk("s3_count", routed_count, 16'd2);
        in_valid = 1'b0; out_ready = 4'b1111;
        tick();
        chk("s3_drained", out_valid, 4'b0000);
        out_ready = 4'b0000;

        pulse_reset();
        in_valid = 1'b1;
        Select = 2'd0; DATAin = 8'h11; tick();
        Select = 2'd1; DATAin = 8'h22; tick();
        Select = 2'd3; DATAin = 8'h33; tick();
        in_valid = 1'b0;
        chk("s4_out_valid", out_valid, 4'b1011);
        chk("s4_DATAout", DATAout, 32'h3300_2211);
        chk("s4_count", routed_count, 16'd3);
        out_ready = 4'b0001;
        tick();
        chk("s4_pop_valid", out_valid, 4'b1010);
        chk("s4_slice0_kept", DATAout[7:0], 8'h11);

        out_ready = 4'b0000; in_valid = 1'b1; Select = 2'd0; DATAin = 8'h44;
        tick();
        in_valid = 1'b0;
        chk("s6_pre_valid", out_valid, 4'b1011);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", out_valid, 4'b0000);
        chk("s6_rst_data", DATAout, 32'h0);
        chk("s6_rst_count", routed_count, 16'd0);
        chk("s6_rst_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        in_valid = 1'b1; Select = 2'd1; DATAin = 8'h5A;
        tick();
        in_valid = 1'b0;
        chk("s6_after_valid", out_valid, 4'b0010);

        // Counter wrap on the CNT_W=4 instance
        pulse_reset();
        out_ready = 4'b1111; in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            Select = 2'(k);
            DATAin = 8'($urandom);
            tick();
            if (k == 15) begin
                chk("s5_wrap0", routed_count4, 4'd0);
                chk("s5_count16", routed_count, 16'd16);
            end
            if (k == 16) chk("s5_wrap1", routed_count4, 4'd1);
        end
        in_valid = 1'b0;

        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) pulse_reset();
            out_ready = 4'($urandom_range(0, 15));
            if (!stall_prev) begin
                in_valid = ($urandom_range(0, 3) != 0);
                Select = 2'($urandom);
                DATAin = 8'($urandom);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
